// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_gen
// Purpose  : Multi-channel LED pattern generator. One free-running prescaler
//            produces a base tick; each channel divides that tick by its own
//            rate and drives its LED as OFF, ON, BLINK or triangle-wave PWM
//            BREATHE. Channels are reconfigured at runtime via a one-cycle
//            write port.
// Ports    : clk       fabric clock
//            rst       asynchronous active-high reset
//            cfg_we    config write strobe (one cycle)
//            cfg_ch    target channel; values >= CHANNELS are ignored
//            cfg_mode  0 OFF, 1 ON, 2 BLINK, 3 BREATHE
//            cfg_rate  channel steps every (rate+1) base ticks
//            led       registered LED drive, bit i = channel i
//            tick      registered one-cycle pulse per prescaler wrap
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
    parameter  int CHANNELS = 4,
    parameter  int PRESC_W  = 21,
    parameter  int RATE_W   = 4,
    parameter  int PWM_W    = 8,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [RATE_W-1:0]   cfg_rate,
    output logic [CHANNELS-1:0] led,
    output logic                tick
);

    localparam logic [1:0] c_MODE_OFF     = 2'd0;
    localparam logic [1:0] c_MODE_ON      = 2'd1;
    localparam logic [1:0] c_MODE_BLINK   = 2'd2;
    localparam logic [1:0] c_MODE_BREATHE = 2'd3;

    localparam logic [PWM_W-1:0] c_LVL_MAX = {PWM_W{1'b1}};

    logic [PRESC_W-1:0] r_presc;
    logic               r_tick;
    logic               w_ptick;
    logic [PWM_W-1:0]   w_pcnt;

    // Base tick fires on the last count before the wrap.
    assign w_ptick = &r_presc;
    // Low prescaler bits double as the shared PWM compare counter.
    assign w_pcnt  = r_presc[PWM_W-1:0];
    assign tick    = r_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
            r_tick  <= w_ptick;
        end
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic [1:0]        r_mode;
            logic [RATE_W-1:0] r_rate;
            logic [RATE_W-1:0] r_rcnt;
            logic              r_phase;
            logic [PWM_W-1:0]  r_lvl;
            logic              r_dir;
            logic              r_led;
            logic              w_wr;
            logic              w_rmatch;

            // Out-of-range channel numbers never match any instance.
            assign w_wr     = cfg_we && (cfg_ch == CH_W'(i));
            assign w_rmatch = (r_rcnt == r_rate);
            assign led[i]   = r_led;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_mode  <= c_MODE_OFF;
                    r_rate  <= '0;
                    r_rcnt  <= '0;
                    r_phase <= 1'b0;
                    r_lvl   <= '0;
                    r_dir   <= 1'b0;
                    r_led   <= 1'b0;
                end else begin
                    // LED follows the state as it stood before this edge.
                    case (r_mode)
                        c_MODE_OFF:   r_led <= 1'b0;
                        c_MODE_ON:    r_led <= 1'b1;
                        c_MODE_BLINK: r_led <= r_phase;
                        default:      r_led <= (w_pcnt < r_lvl);
                    endcase

                    if (w_wr) begin
                        // A write restarts the pattern and swallows any
                        // step that coincides with it.
                        r_mode  <= cfg_mode;
                        r_rate  <= cfg_rate;
                        r_rcnt  <= '0;
                        r_phase <= 1'b0;
                        r_lvl   <= '0;
                        r_dir   <= 1'b0;
                    end else if (w_ptick) begin
                        if (w_rmatch) begin
                            r_rcnt <= '0;
                        end else begin
                            r_rcnt <= r_rcnt + RATE_W'(1);
                        end

                        if (w_rmatch && (r_mode == c_MODE_BLINK)) begin
                            r_phase <= ~r_phase;
                        end

                        if (w_rmatch && (r_mode == c_MODE_BREATHE)) begin
                            if (!r_dir) begin
                                if (r_lvl == c_LVL_MAX) begin
                                    r_dir <= 1'b1;
                                    r_lvl <= r_lvl - PWM_W'(1);
                                end else begin
                                    r_lvl <= r_lvl + PWM_W'(1);
                                end
                            end else begin
                                if (r_lvl == '0) begin
                                    r_dir <= 1'b0;
                                    r_lvl <= PWM_W'(1);
                                end else begin
                                    r_lvl <= r_lvl - PWM_W'(1);
                                end
                            end
                        end
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_gen
// Purpose  : Self-checking bench for led_pattern_gen with a behavioural model
//            that derives every LED from the number of base ticks seen since
//            the channel was last configured.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

    localparam int CHANNELS = 3;
    localparam int PRESC_W  = 4;
    localparam int RATE_W   = 2;
    localparam int PWM_W    = 3;
    localparam int PRESC_N  = 1 << PRESC_W;
    localparam int PWM_N    = 1 << PWM_W;
    localparam int LVL_MAX  = PWM_N - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_we = 1'b0;
    logic [1:0]          cfg_ch = '0;
    logic [1:0]          cfg_mode = '0;
    logic [RATE_W-1:0]   cfg_rate = '0;
    logic [CHANNELS-1:0] led;
    logic                tick;

    int vectors = 0;
    int miscompares = 0;

    led_pattern_gen #(
        .CHANNELS (CHANNELS),
        .PRESC_W  (PRESC_W),
        .RATE_W   (RATE_W),
        .PWM_W    (PWM_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_rate (cfg_rate),
        .led      (led),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int                  m_presc = 0;
    int                  m_mode [CHANNELS];
    int                  m_rate [CHANNELS];
    int                  m_n    [CHANNELS];   // base ticks since last write
    logic [CHANNELS-1:0] exp_led = '0;
    logic                exp_tick = 1'b0;

    // Triangle brightness after k steps: 0,1,..,MAX,MAX-1,..,0,1,...
    function automatic int tri_lvl(input int k);
        int m;
        m = k % (2 * LVL_MAX);
        return (m <= LVL_MAX) ? m : (2 * LVL_MAX - m);
    endfunction

    function automatic int steps_of(input int i);
        return m_n[i] / (m_rate[i] + 1);
    endfunction

    function automatic logic model_led(input int i);
        case (m_mode[i])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return logic'(steps_of(i) % 2);
            default: return ((m_presc % PWM_N) < tri_lvl(steps_of(i)));
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [CHANNELS-1:0] nl;
        if (rst) begin
            m_presc  = 0;
            exp_led  = '0;
            exp_tick = 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                m_mode[i] = 0;
                m_rate[i] = 0;
                m_n[i]    = 0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) nl[i] = model_led(i);
            exp_tick = (m_presc == PRESC_N - 1);
            for (int i = 0; i < CHANNELS; i++) begin
                if (cfg_we && (int'(cfg_ch) == i)) begin
                    m_mode[i] = int'(cfg_mode);
                    m_rate[i] = int'(cfg_rate);
                    m_n[i]    = 0;
                end else if (m_presc == PRESC_N - 1) begin
                    m_n[i] = m_n[i] + 1;
                end
            end
            m_presc = (m_presc + 1) % PRESC_N;
            exp_led = nl;
        end
    end

    // Drive a one-cycle config write; called at a falling edge.
    task automatic wr(input int ch, input int mode, input int rate);
        cfg_ch   = 2'(ch);
        cfg_mode = 2'(mode);
        cfg_rate = RATE_W'(rate);
        cfg_we   = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int first;
        first = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (led !== 3'b000 || tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: led=%b tick=%b expected led=000 tick=0", led, tick);
        end
        rst = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            vectors++;
            if (led !== exp_led || tick !== exp_tick) begin
                miscompares++;
                $display("FAIL idle c=%0d: led=%b tick=%b expected led=%b tick=%b",
                         c, led, tick, exp_led, exp_tick);
            end
            if (tick === 1'b1 && first == 0) first = c;
        end
        vectors++;
        if (first != 16) begin
            miscompares++;
            $display("FAIL first_tick: got cycle %0d expected 16", first);
        end
    endtask

    task automatic test_on_blink();
        int t0, t1;
        t0 = -1;
        t1 = -1;
        wr(0, 1, 0);
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            cfg_we = 1'b0;
            vectors++;
            if (led !== exp_led) begin
                miscompares++;
                $display("FAIL on j=%0d: led=%b expected %b", j, led, exp_led);
            end
            if (j == 2) begin
                vectors++;
                if (led[0] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL on_latency: led0=%b expected 1", led[0]);
                end
            end
        end
        wr(1, 2, 1);
        for (int j = 1; j <= 110; j++) begin
            logic prev;
            prev = led[1];
            @(negedge clk);
            cfg_we = 1'b0;
            vectors++;
            if (led !== exp_led || tick !== exp_tick) begin
                miscompares++;
                $display("FAIL blink j=%0d: led=%b tick=%b expected led=%b tick=%b",
                         j, led, tick, exp_led, exp_tick);
            end
            if (j > 1 && led[1] !== prev) begin
                if (t0 < 0) t0 = j;
                else if (t1 < 0) t1 = j;
            end
        end
        vectors++;
        if (t0 < 0 || t1 < 0 || (t1 - t0) != 32) begin
            miscompares++;
            $display("FAIL blink_period: toggles at %0d,%0d expected spacing 32", t0, t1);
        end
    endtask

    task automatic test_breathe();
        int  highs;
        bit  done;
        done = 1'b0;
        wr(2, 3, 0);
        for (int j = 1; j <= 300; j++) begin
            @(negedge clk);
            cfg_we = 1'b0;
            vectors++;
            if (led !== exp_led || tick !== exp_tick) begin
                miscompares++;
                $display("FAIL breathe j=%0d: led=%b tick=%b expected led=%b tick=%b",
                         j, led, tick, exp_led, exp_tick);
            end
            // Samples at presc 4..11 show pcnt 3..7,0..2 with steady lvl.
            if (!done && m_presc == 4 && tri_lvl(steps_of(2)) == 3) begin
                done  = 1'b1;
                highs = 0;
                for (int s = 0; s < 8; s++) begin
                    highs += int'(led[2]);
                    if (s < 7) @(negedge clk);
                end
                vectors++;
                if (highs != 3) begin
                    miscompares++;
                    $display("FAIL breathe_duty: led2 high %0d of 8 expected 3", highs);
                end
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL breathe_lvl3: level 3 not reached, got 0 expected 1");
        end
    endtask

    task automatic test_collision();
        bit found;
        found = 1'b0;
        for (int j = 0; j < 200 && !found; j++) begin
            @(negedge clk);
            if (m_presc == PRESC_N - 1 && (m_n[1] % 2) == 1) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL collision_wait: timeout got 0 expected 1");
        end
        wr(1, 2, 1);
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            cfg_we = 1'b0;
            vectors++;
            if (led !== exp_led || tick !== exp_tick) begin
                miscompares++;
                $display("FAIL collision j=%0d: led=%b tick=%b expected led=%b tick=%b",
                         j, led, tick, exp_led, exp_tick);
            end
            if (j >= 2) begin
                vectors++;
                if (led[1] !== 1'b0 || led[0] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL collision_hold j=%0d: led1=%b led0=%b expected led1=0 led0=1",
                             j, led[1], led[0]);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        wr(3, 1, 3);
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            cfg_we = 1'b0;
            vectors++;
            if (led !== exp_led || tick !== exp_tick) begin
                miscompares++;
                $display("FAIL out_of_range j=%0d: led=%b tick=%b expected led=%b tick=%b",
                         j, led, tick, exp_led, exp_tick);
            end
        end
    endtask

    task automatic test_async_reset();
        bit found;
        found = 1'b0;
        for (int j = 0; j < 400 && !found; j++) begin
            @(negedge clk);
            if (m_mode[2] == 3 && tri_lvl(steps_of(2)) == 5 && m_presc == 8) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL async_wait: lvl 5 not reached, got 0 expected 1");
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (led !== 3'b000 || tick !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: led=%b tick=%b expected led=000 tick=0", led, tick);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            vectors++;
            if (led !== 3'b000 || led !== exp_led || tick !== exp_tick) begin
                miscompares++;
                $display("FAIL post_reset j=%0d: led=%b tick=%b expected led=000 tick=%b",
                         j, led, tick, exp_tick);
            end
        end
    endtask

    task automatic test_random();
        for (int j = 1; j <= 1500; j++) begin
            @(negedge clk);
            cfg_we = 1'b0;
            vectors++;
            if (led !== exp_led || tick !== exp_tick) begin
                miscompares++;
                $display("FAIL random j=%0d: led=%b tick=%b expected led=%b tick=%b",
                         j, led, tick, exp_led, exp_tick);
            end
            if ($urandom_range(0, 15) == 0) begin
                wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_on_blink();
        test_breathe();
        test_collision();
        test_out_of_range();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Multi-channel LED pattern generator, successor to the single fixed-rate counter blinker. Runs on the PLL-derived fabric clock. Drives CHANNELS LED outputs, each independently configured at runtime through a one-cycle write port. Supported modes per channel: off, on, blink at a programmable rate, or triangle-wave PWM "breathe". All channels share one free-running prescaler.

Parameters:
CHANNELS, 4, number of LED outputs (>=1)
PRESC_W, 21, prescaler width; base tick every 2^PRESC_W clk cycles
RATE_W, 4, per-channel rate divider width; channel steps every (rate+1) ticks
PWM_W, 8, breathe brightness resolution; must satisfy PWM_W <= PRESC_W

Ports:
clk  input  1  fabric clock (PLL CLK0 domain)
rst  input  1  asynchronous, active-high reset
cfg_we  input  1  config write strobe, one cycle
cfg_ch  input  CH_W  target channel, CH_W = max(1, clog2(CHANNELS))
cfg_mode  input  2  0 OFF, 1 ON, 2 BLINK, 3 BREATHE
cfg_rate  input  RATE_W  step divider value
led  output  CHANNELS  LED drive, bit i = channel i
tick  output  1  registered one-cycle pulse per prescaler wrap

Behaviour:
- Reset (async assert, sync deassert assumed upstream): prescaler=0, tick=0, led=0; every channel mode=OFF, rate=0, rcnt=0, phase=0, lvl=0, dir=0.
- Prescaler: increments every clk and wraps from 2^PRESC_W-1 to 0. ptick = (prescaler == 2^PRESC_W-1), combinational internal signal. tick output = ptick registered, i.e. high in the cycle where prescaler reads 0 after a wrap.
- pcnt = prescaler[PWM_W-1:0], the shared PWM compare counter.
- Per-channel step: on ptick, if rcnt == rate then rcnt<=0 and step=1, else rcnt<=rcnt+1. Step period = (rate+1)*2^PRESC_W cycles.
- OFF: led_i next = 0. ON: led_i next = 1. State regs hold, except that rcnt keeps counting.
- BLINK: phase toggles on step; led_i next = phase. One full blink period = 2*(rate+1)*2^PRESC_W cycles.
- BREATHE, on each step:
  - dir=0: if lvl == 2^PWM_W-1 then dir<=1, lvl<=lvl-1; else lvl<=lvl+1.
  - dir=1: if lvl == 0 then dir<=0, lvl<=1; else lvl<=lvl-1.
  - led_i next = (pcnt < lvl). lvl=0 gives always off; max gives off for one pcnt slot per PWM period.
- led is registered: one-cycle latency from state/pcnt to pin.
- Config write: on the clk edge with cfg_we=1 and cfg_ch < CHANNELS, channel cfg_ch loads mode and rate, and clears rcnt, phase, lvl and dir. The write takes precedence over a step on the same edge, so that step is lost for that channel. Other channels are unaffected. A write with cfg_ch >= CHANNELS is ignored.
- Rewriting the same mode/rate restarts that channel's pattern from phase 0.
- Reset asserted mid-operation returns everything to reset values immediately, with no pending state retained.
- Widths: rcnt is RATE_W bits; rate = 2^RATE_W-1 is legal. The prescaler wraps with no overflow flag.

Test Plan:
(Bench uses PRESC_W=4, PWM_W=3, RATE_W=2, CHANNELS=3.)
- Reset held 5 cycles then released, no writes -> led=000 forever; tick pulses every 16 cycles, first pulse 16 cycles after release.
- Write ch0 mode=ON, then ch1 mode=BLINK rate=1 -> led[0]=1 from the cycle after the write +1; led[1] toggles every 32 cycles.
- Write ch2 BREATHE rate=0 -> lvl sequence 1,2,...,7,6,...,0,1 across successive ticks. At lvl=3, led[2] is high for exactly 3 of each 8 pcnt cycles.
- cfg_we on the exact cycle ptick and step coincide for ch1 -> ch1 rcnt=0 and phase=0 after the edge, and led[1] does not toggle. ch0 is unaffected.
- Write with cfg_ch=3 (out of range) -> no change in any channel state or led.
- Assert rst mid-BREATHE at lvl=5 -> led=000 asynchronously on the next sample. After release, all channels are OFF until rewritten.
